// File: rtl/ps2_host_tx.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : ps2_host_tx                                                   |
// | Description : Host-to-device PS/2 command transmitter (open-drain outputs). |
// |               Optional macro PS2_TX_GLITCH_FILTER_EN adds an 8-sample clock |
// |               stability filter.                                             |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module ps2_host_tx #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int INHIBIT_US = 100,
    parameter int TIMEOUT_US = 15000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2k_clk_in,
    input  logic       ps2k_data_in,
    output logic       ps2k_clk_oe,
    output logic       ps2k_data_oe,
    output logic       rx_inhibit,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int c_CYC_PER_US = CLK_HZ / 1_000_000;
    localparam int c_INH_CYC    = c_CYC_PER_US * INHIBIT_US;
    localparam int c_TO_CYC     = c_CYC_PER_US * TIMEOUT_US;
    localparam int c_MAX_CYC    = (c_INH_CYC > c_TO_CYC) ? c_INH_CYC : c_TO_CYC;
    localparam int c_CNT_W      = (c_MAX_CYC < 1) ? 1 : $clog2(c_MAX_CYC + 1);

    localparam logic [c_CNT_W-1:0] c_INH_LD = c_CNT_W'(c_INH_CYC);
    localparam logic [c_CNT_W-1:0] c_TO_LD  = c_CNT_W'(c_TO_CYC);
    localparam logic [c_CNT_W-1:0] c_ONE    = c_CNT_W'(1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_INHIBIT   = 3'd1;
    localparam logic [2:0] S_REQ       = 3'd2;
    localparam logic [2:0] S_SEND      = 3'd3;
    localparam logic [2:0] S_ACK       = 3'd4;
    localparam logic [2:0] S_WAIT_IDLE = 3'd5;

    logic [2:0]         r_state;
    logic [2:0]         w_next;
    logic               r_clk_s1;
    logic               r_clk_s2;
    logic               r_data_s1;
    logic               r_data_s2;
    logic               r_clk_prev;
    logic               w_clk_f;
    logic               w_fe;
    logic [7:0]         r_byte;
    logic               r_par;
    logic [c_CNT_W-1:0] r_cnt;
    logic [3:0]         r_bit_n;
    logic               r_data_oe;
    logic               r_tx_done;
    logic               r_tx_error;
    logic               w_done;
    logic               w_err;
    logic               w_to_active;
    logic               w_to_exp;

    // Idle-high reset values keep a spurious falling edge out of the first cycles.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_clk_s1  <= 1'b1;
            r_clk_s2  <= 1'b1;
            r_data_s1 <= 1'b1;
            r_data_s2 <= 1'b1;
        end else begin
            r_clk_s1  <= ps2k_clk_in;
            r_clk_s2  <= r_clk_s1;
            r_data_s1 <= ps2k_data_in;
            r_data_s2 <= r_data_s1;
        end
    end

`ifdef PS2_TX_GLITCH_FILTER_EN
    logic       r_clk_filt;
    logic [2:0] r_filt_cnt;

    // Flip only after eight consecutive samples disagree with the held level.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_clk_filt <= 1'b1;
            r_filt_cnt <= 3'd0;
        end else if (r_clk_s2 == r_clk_filt) begin
            r_filt_cnt <= 3'd0;
        end else if (r_filt_cnt == 3'd7) begin
            r_clk_filt <= r_clk_s2;
            r_filt_cnt <= 3'd0;
        end else begin
            r_filt_cnt <= r_filt_cnt + 3'd1;
        end
    end

    assign w_clk_f = r_clk_filt;
`else
    assign w_clk_f = r_clk_s2;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_clk_prev <= 1'b1;
        end else begin
            r_clk_prev <= w_clk_f;
        end
    end

    assign w_fe        = r_clk_prev & ~w_clk_f;
    assign w_to_active = (r_state == S_SEND) || (r_state == S_ACK) || (r_state == S_WAIT_IDLE);
    assign w_to_exp    = w_to_active && (r_cnt == '0) && !w_fe;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_done = 1'b0;
        w_err  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (tx_valid) begin
                    w_next = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (r_cnt <= c_ONE) begin
                    w_next = S_REQ;
                end
            end
            S_REQ: begin
                w_next = S_SEND;
            end
            S_SEND: begin
                if (w_to_exp) begin
                    w_err  = 1'b1;
                    w_next = S_IDLE;
                end else if (w_fe && (r_bit_n == 4'd9)) begin
                    w_next = S_ACK;
                end
            end
            S_ACK: begin
                if (w_to_exp) begin
                    w_err  = 1'b1;
                    w_next = S_IDLE;
                end else if (w_fe) begin
                    if (r_data_s2) begin
                        w_err  = 1'b1;
                        w_next = S_IDLE;
                    end else begin
                        w_next = S_WAIT_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (w_to_exp) begin
                    w_err  = 1'b1;
                    w_next = S_IDLE;
                end else if (w_clk_f && r_data_s2) begin
                    w_done = 1'b1;
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Shared counter: inhibit time first, then the inter-edge timeout.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_byte     <= 8'd0;
            r_par      <= 1'b0;
            r_cnt      <= '0;
            r_bit_n    <= 4'd0;
            r_data_oe  <= 1'b0;
            r_tx_done  <= 1'b0;
            r_tx_error <= 1'b0;
        end else begin
            r_tx_done  <= w_done;
            r_tx_error <= w_err;
            case (r_state)
                S_IDLE: begin
                    if (tx_valid) begin
                        r_byte <= tx_data;
                        r_par  <= ~^tx_data;
                        r_cnt  <= c_INH_LD;
                    end
                end
                S_INHIBIT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - c_ONE;
                    end
                end
                S_REQ: begin
                    r_cnt     <= c_TO_LD;
                    r_bit_n   <= 4'd0;
                    r_data_oe <= 1'b1;
                end
                S_SEND, S_ACK, S_WAIT_IDLE: begin
                    if (w_fe) begin
                        r_cnt <= c_TO_LD;
                    end else if (r_cnt != '0) begin
                        r_cnt <= r_cnt - c_ONE;
                    end
                    if ((r_state == S_SEND) && w_fe) begin
                        r_bit_n <= r_bit_n + 4'd1;
                        if (r_bit_n < 4'd8) begin
                            r_data_oe <= ~r_byte[r_bit_n[2:0]];
                        end else if (r_bit_n == 4'd8) begin
                            r_data_oe <= ~r_par;
                        end else begin
                            r_data_oe <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    always_comb begin
        tx_ready     = (r_state == S_IDLE);
        rx_inhibit   = (r_state != S_IDLE);
        ps2k_clk_oe  = (r_state == S_INHIBIT) || (r_state == S_REQ);
        ps2k_data_oe = 1'b0;
        if (r_state == S_REQ) begin
            ps2k_data_oe = 1'b1;
        end else if (r_state == S_SEND) begin
            ps2k_data_oe = r_data_oe;
        end
        tx_done      = r_tx_done;
        tx_error     = r_tx_error;
    end

endmodule
`default_nettype wire
